// File: rtl/press_decoder.sv
// press_decoder: classifies debounced button activity into short, double and long presses with auto-repeat
module press_decoder #(
    parameter int CNT_W       = 26,
    parameter int LONG_TIME   = 50_000_000,
    parameter int DOUBLE_GAP  = 15_000_000,
    parameter int REPEAT_TIME = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    input  logic btn_rise,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_tick,
    output logic holding
);
    typedef enum logic [2:0] {IDLE, PRESSED1, WAIT_GAP, PRESSED2, LONG_HELD} state_t;
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic short_nx, double_nx, long_nx, repeat_nx, holding_nx;
    // State, counter and all outputs are registered so no output sees inputs combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_tick  <= 1'b0;
            holding      <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            short_press  <= short_nx;
            double_press <= double_nx;
            long_press   <= long_nx;
            repeat_tick  <= repeat_nx;
            holding      <= holding_nx;
        end
    end
    // Next state: release beats timeout while pressed; a new rise beats the gap timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (btn_rise) state_nx = PRESSED1;
            PRESSED1:  state_nx = !btn_level ? WAIT_GAP : (cnt == LONG_LAST) ? LONG_HELD : PRESSED1;
            WAIT_GAP:  state_nx = btn_rise ? PRESSED2 : (cnt == GAP_LAST) ? IDLE : WAIT_GAP;
            PRESSED2:  state_nx = !btn_level ? IDLE : (cnt == LONG_LAST) ? LONG_HELD : PRESSED2;
            LONG_HELD: if (!btn_level) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end
    // Pulse and counter next values; the counter restarts on every state entry and on each repeat tick
    always_comb begin
        short_nx   = state == WAIT_GAP && !btn_rise && cnt == GAP_LAST;
        long_nx    = state == PRESSED1 && btn_level && cnt == LONG_LAST;
        double_nx  = state == PRESSED2 && (!btn_level || cnt == LONG_LAST);
        repeat_nx  = state == LONG_HELD && btn_level && cnt == REPEAT_LAST;
        holding_nx = state_nx == LONG_HELD;
        cnt_nx     = (state_nx != state || state == IDLE || repeat_nx) ? '0 : cnt + 1'b1;
    end
endmodule

// File: tb/tb_press_decoder.sv
// tb_press_decoder: scenario and random checks of press_decoder against a timestamp-based press model
module tb_press_decoder;
    localparam int L = 8, G = 5, R = 4;
    logic clk = 1'b0, rst = 1'b1, btn_level = 1'b0, btn_rise = 1'b0;
    logic short_press, double_press, long_press, repeat_tick, holding;
    press_decoder #(.CNT_W(8), .LONG_TIME(L), .DOUBLE_GAP(G), .REPEAT_TIME(R)) dut (
        .clk(clk), .rst(rst), .btn_level(btn_level), .btn_rise(btn_rise),
        .short_press(short_press), .double_press(double_press), .long_press(long_press),
        .repeat_tick(repeat_tick), .holding(holding)
    );
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0, cyc_err = 0;
    int n_s, n_d, n_l, n_r, n_multi, c_s, c_d, c_l, c_r1;
    // model: a press sequence is a run of timestamps, not a state machine
    bit m_act, m_down, m_long;
    int m_presses, m_mark;
    bit e_s, e_d, e_l, e_r, e_h;

    task automatic model(input bit r, input bit lv, input bit rs);
        {e_s, e_d, e_l, e_r} = '0;
        if (rs) begin
            m_act = 0;
        end else if (!m_act) begin
            if (r) begin
                m_act = 1; m_down = 1; m_long = 0; m_presses = 1; m_mark = cyc;
            end
        end else if (m_long) begin
            if (!lv) m_act = 0;
            else if ((cyc - m_mark) % R == 0) e_r = 1;
        end else if (m_down) begin
            if (!lv) begin
                if (m_presses == 1) begin m_down = 0; m_mark = cyc; end
                else begin e_d = 1; m_act = 0; end
            end else if (cyc - m_mark == L) begin
                if (m_presses == 1) e_l = 1; else e_d = 1;
                m_long = 1; m_mark = cyc;
            end
        end else begin
            if (r) begin m_presses = 2; m_down = 1; m_mark = cyc; end
            else if (cyc - m_mark == G) begin e_s = 1; m_act = 0; end
        end
        e_h = m_act && m_long;
    endtask

    task automatic step(input bit r, input bit lv, input bit rs);
        btn_rise = r; btn_level = lv; rst = rs;
        @(posedge clk);
        cyc++;
        model(r, lv, rs);
        #1;
        if ({short_press, double_press, long_press, repeat_tick, holding} !== {e_s, e_d, e_l, e_r, e_h}) begin
            cyc_err++;
            if (cyc_err <= 5)
                $display("[TB] divergence cycle %0d: dut s/d/l/r/h=%b model=%b", cyc,
                         {short_press, double_press, long_press, repeat_tick, holding}, {e_s, e_d, e_l, e_r, e_h});
        end
        if (short_press === 1'b1) begin n_s++; c_s = cyc; end
        if (double_press === 1'b1) begin n_d++; c_d = cyc; end
        if (long_press === 1'b1) begin n_l++; c_l = cyc; end
        if (repeat_tick === 1'b1) begin if (n_r == 0) c_r1 = cyc; n_r++; end
        if (int'(short_press) + int'(double_press) + int'(long_press) + int'(repeat_tick) > 1) n_multi++;
    endtask

    task automatic clr();
        n_s = 0; n_d = 0; n_l = 0; n_r = 0; n_multi = 0; c_s = -1; c_d = -1; c_l = -1; c_r1 = -1; cyc_err = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic test_reset();
        clr();
        step(0, 0, 1); step(1, 1, 1); step(0, 1, 1);
        tests++;
        if ({short_press, double_press, long_press, repeat_tick, holding} !== 5'b0) begin
            fails++; $display("FAIL reset_outputs: got %b want 00000", {short_press, double_press, long_press, repeat_tick, holding});
        end
        tests++;
        if (n_s + n_d + n_l + n_r != 0) begin fails++; $display("FAIL reset_no_pulse: got %0d pulses want 0", n_s + n_d + n_l + n_r); end
        idle(2);
    endtask

    task automatic test_short();
        int w0;
        clr();
        step(1, 1, 0); step(0, 1, 0); step(0, 1, 0);
        step(0, 0, 0); w0 = cyc;
        idle(10);
        tests++;
        if (n_s != 1 || n_d + n_l + n_r != 0) begin fails++; $display("FAIL short_count: got s=%0d d=%0d l=%0d r=%0d want 1/0/0/0", n_s, n_d, n_l, n_r); end
        tests++;
        if (c_s - w0 != G) begin fails++; $display("FAIL short_timing: got %0d want %0d cycles after gap entry", c_s - w0, G); end
        tests++;
        if (cyc_err != 0) begin fails++; $display("FAIL short_model: got %0d divergent cycles want 0", cyc_err); end
    endtask

    task automatic test_double();
        int rel;
        clr();
        step(1, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
        step(1, 1, 0); step(0, 1, 0); step(0, 0, 0); rel = cyc;
        idle(8);
        tests++;
        if (n_d != 1 || n_s != 0 || n_l != 0) begin fails++; $display("FAIL double_count: got d=%0d s=%0d l=%0d want 1/0/0", n_d, n_s, n_l); end
        tests++;
        if (c_d != rel) begin fails++; $display("FAIL double_timing: got cycle %0d want %0d", c_d, rel); end
    endtask

    task automatic test_long();
        int c;
        clr();
        step(1, 1, 0); c = cyc;
        for (int i = 0; i < 19; i++) step(0, 1, 0);
        tests++;
        if (holding !== 1'b1) begin fails++; $display("FAIL long_holding_on: got %b want 1", holding); end
        step(0, 0, 0);
        tests++;
        if (holding !== 1'b0) begin fails++; $display("FAIL long_holding_off: got %b want 0", holding); end
        idle(6);
        tests++;
        if (n_l != 1 || c_l - c != L) begin fails++; $display("FAIL long_timing: got n=%0d offset=%0d want 1/%0d", n_l, c_l - c, L); end
        tests++;
        if (n_r != 2 || c_r1 - c != L + R) begin fails++; $display("FAIL long_repeat: got n=%0d first=%0d want 2/%0d", n_r, c_r1 - c, L + R); end
        tests++;
        if (n_s + n_d != 0 || cyc_err != 0) begin fails++; $display("FAIL long_other: got s+d=%0d err=%0d want 0/0", n_s + n_d, cyc_err); end
    endtask

    task automatic test_gap_boundary();
        clr();
        step(1, 1, 0); step(0, 1, 0); step(0, 1, 0);
        step(0, 0, 0);
        for (int i = 0; i < G - 1; i++) step(0, 0, 0);
        step(1, 1, 0); step(0, 1, 0); step(0, 0, 0);
        idle(8);
        tests++;
        if (n_s != 0 || n_d != 1) begin fails++; $display("FAIL gap_boundary: got s=%0d d=%0d want 0/1", n_s, n_d); end
    endtask

    task automatic test_reset_mid();
        clr();
        step(1, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 0, 1);
        tests++;
        if ({short_press, double_press, long_press, repeat_tick, holding} !== 5'b0) begin
            fails++; $display("FAIL reset_gap: got %b want 00000", {short_press, double_press, long_press, repeat_tick, holding});
        end
        idle(8);
        step(1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        step(0, 1, 1);
        tests++;
        if ({short_press, double_press, long_press, repeat_tick, holding} !== 5'b0) begin
            fails++; $display("FAIL reset_held: got %b want 00000", {short_press, double_press, long_press, repeat_tick, holding});
        end
        for (int i = 0; i < 6; i++) step(0, 1, 0);
        idle(3);
        tests++;
        if (n_s + n_d + n_r != 0 || n_l != 1) begin fails++; $display("FAIL reset_abort: got s=%0d d=%0d l=%0d r=%0d want 0/0/1/0", n_s, n_d, n_l, n_r); end
        step(1, 1, 0); step(0, 1, 0); step(0, 0, 0);
        idle(8);
        tests++;
        if (n_s != 1 || cyc_err != 0) begin fails++; $display("FAIL reset_recover: got s=%0d err=%0d want 1/0", n_s, cyc_err); end
    endtask

    task automatic test_ignored();
        clr();
        for (int i = 0; i < 12; i++) step(0, 1, 0);
        idle(2);
        tests++;
        if (n_s + n_d + n_l + n_r != 0 || holding !== 1'b0) begin fails++; $display("FAIL ignore_level: got %0d pulses holding=%b want 0/0", n_s + n_d + n_l + n_r, holding); end
        step(1, 1, 0); step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 0, 0);
        idle(8);
        tests++;
        if (n_s != 1 || n_d + n_l + n_r != 0) begin fails++; $display("FAIL ignore_rise: got s=%0d d=%0d l=%0d r=%0d want 1/0/0/0", n_s, n_d, n_l, n_r); end
    endtask

    task automatic test_random();
        clr();
        for (int s = 0; s < 60; s++) begin
            int hold = $urandom_range(1, 14);
            int rel = $urandom_range(1, 8);
            for (int i = 0; i < hold; i++) step(i == 0 || $urandom_range(0, 7) == 0, 1, $urandom_range(0, 59) == 0);
            for (int i = 0; i < rel; i++) step(0, 0, $urandom_range(0, 59) == 0);
        end
        idle(12);
        tests++;
        if (cyc_err != 0) begin fails++; $display("FAIL random_model: got %0d divergent cycles want 0", cyc_err); end
        tests++;
        if (n_multi != 0) begin fails++; $display("FAIL random_exclusive: got %0d multi-pulse cycles want 0", n_multi); end
    endtask

    initial begin
        test_reset();
        test_short();
        test_double();
        test_long();
        test_gap_boundary();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
